// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types and segment patterns for the BCD display scanner
package bcd_disp_pkg;

  typedef enum logic [1:0] {S_LO, S_GAP_LO, S_HI, S_GAP_HI} state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD nibble to 7-segment encoder, dash for A..F
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - two-digit multiplexed 7-segment scanner with shadow load,
// dead-time, leading-zero blanking and optional active-low pins
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES   = 1000,
  parameter int GAP_CYCLES     = 16,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd,
  input  logic       ld,
  input  logic       en,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int            CW       = $clog2(max3(DIGIT_CYCLES, GAP_CYCLES, 2));
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [6:0]    SEG_XOR  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_XOR   = (SEG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          run, run_n;
  logic [7:0]    shadow;
  logic [3:0]    digit, digit_n;
  logic          slot_last;
  logic [6:0]    enc_seg, seg_d;
  logic [1:0]    an_d;

  // run is low after reset or while disabled; the first enabled edge starts a fresh S_LO slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 8'h00;
      state  <= S_LO;
      cnt    <= '0;
      run    <= 1'b0;
      digit  <= 4'h0;
    end else begin
      if (ld) shadow <= bcd;
      state <= state_n;
      cnt   <= cnt_n;
      run   <= run_n;
      digit <= digit_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    run_n     = run;
    digit_n   = digit;
    slot_last = (state == S_LO || state == S_HI) ? (cnt == DIG_LAST) : (cnt == GAP_LAST);
    if (!en) begin
      state_n = S_LO;
      cnt_n   = '0;
      run_n   = 1'b0;
    end else if (!run) begin
      state_n = S_LO;
      cnt_n   = '0;
      run_n   = 1'b1;
      digit_n = shadow[3:0];
    end else if (slot_last) begin
      cnt_n = '0;
      unique case (state)
        S_LO:     state_n = HAS_GAP ? S_GAP_LO : S_HI;
        S_GAP_LO: state_n = S_HI;
        S_HI:     state_n = HAS_GAP ? S_GAP_HI : S_LO;
        S_GAP_HI: state_n = S_LO;
      endcase
      // The slot digit is frozen here so a mid-slot load only shows up next time round.
      if (state_n == S_LO)      digit_n = shadow[3:0];
      else if (state_n == S_HI) digit_n = shadow[7:4];
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  bcd_to_7seg u_enc (
    .digit (digit),
    .seg   (enc_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 2'b00;
    if (en && run) begin
      case (state)
        S_LO: begin
          an_d  = 2'b01;
          seg_d = enc_seg;
        end
        S_HI: begin
          if (!(BLANK_LZ != 0 && digit == 4'h0)) begin
            an_d  = 2'b10;
            seg_d = enc_seg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK ^ SEG_XOR;
      an  <= 2'b00 ^ AN_XOR;
    end else begin
      seg <= seg_d ^ SEG_XOR;
      an  <= an_d ^ AN_XOR;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed bench with a scan-position model of the display
module tb_bcd_display_scanner;

  localparam int D = 4;
  localparam int G = 1;
  localparam int P = 2 * D + 2 * G;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld  = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] bcd = 8'h00;
  logic [6:0] seg;
  logic [1:0] an;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .DIGIT_CYCLES   (D),
    .GAP_CYCLES     (G),
    .BLANK_LZ       (1),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bcd (bcd),
    .ld  (ld),
    .en  (en),
    .seg (seg),
    .an  (an)
  );

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Model: position within a P-cycle scan period (-1 = not scanning) plus the per-slot digits.
  logic [7:0] m_shadow = 8'h00;
  int         m_pos = -1;
  logic [3:0] m_units = 4'h0;
  logic [3:0] m_tens = 4'h0;
  logic [6:0] exp_seg = 7'h00;
  logic [1:0] exp_an = 2'b00;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    exp_seg = 7'h00;
    exp_an  = 2'b00;
    if (rst) begin
      m_shadow = 8'h00;
      m_pos    = -1;
      m_valid  = 1'b1;
    end else begin
      if (en && m_pos >= 0) begin
        if (m_pos < D) begin
          exp_an  = 2'b01;
          exp_seg = enc(m_units);
        end else if (m_pos >= D + G && m_pos < 2 * D + G && m_tens != 4'h0) begin
          exp_an  = 2'b10;
          exp_seg = enc(m_tens);
        end
      end
      if (!en) begin
        m_pos = -1;
      end else if (m_pos < 0) begin
        m_pos   = 0;
        m_units = m_shadow[3:0];
      end else begin
        m_pos = (m_pos + 1) % P;
        if (m_pos == 0)     m_units = m_shadow[3:0];
        if (m_pos == D + G) m_tens  = m_shadow[7:4];
      end
      if (ld) m_shadow = bcd;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL model @%0t: an=%b seg=%h, expected an=%b seg=%h",
                 $time, an, seg, exp_an, exp_seg);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_run(input logic [1:0] a, input logic [6:0] s, input int n,
                            input string name);
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (an !== a || seg !== s) begin
        n_bad++;
        $display("FAIL %s[%0d]: an=%b seg=%h, expected an=%b seg=%h", name, i, an, seg, a, s);
      end
      cyc(1);
    end
  endtask

  task automatic wait_for(input logic [1:0] a, input logic [6:0] s, input string name);
    int k;
    k = 0;
    while (!(an === a && seg === s) && k < 40) begin
      cyc(1);
      k++;
    end
    if (k >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting, an=%b seg=%h, expected an=%b seg=%h",
               name, an, seg, a, s);
    end
  endtask

  task automatic load(input logic [7:0] b);
    bcd = b;
    ld  = 1'b1;
    cyc(1);
    ld  = 1'b0;
  endtask

  initial begin
    cyc(2);
    expect_run(2'b00, 7'h00, 1, "reset");
    rst = 1'b0;

    en = 1'b1;
    load(8'h15);
    wait_for(2'b01, 7'h6D, "w15");
    expect_run(2'b01, 7'h6D, 4, "u5");
    expect_run(2'b00, 7'h00, 1, "gap_lo");
    expect_run(2'b10, 7'h06, 4, "t1");
    expect_run(2'b00, 7'h00, 1, "gap_hi");
    expect_run(2'b01, 7'h6D, 4, "u5_again");

    load(8'h07);
    wait_for(2'b01, 7'h07, "w07");
    expect_run(2'b01, 7'h07, 4, "u7");
    expect_run(2'b00, 7'h00, 6, "lz07");
    expect_run(2'b01, 7'h07, 1, "u7_again");

    load(8'h00);
    wait_for(2'b01, 7'h3F, "w00");
    expect_run(2'b01, 7'h3F, 4, "u0");
    expect_run(2'b00, 7'h00, 6, "lz00");
    expect_run(2'b01, 7'h3F, 1, "u0_again");

    load(8'h12);
    wait_for(2'b01, 7'h5B, "w12");
    expect_run(2'b01, 7'h5B, 2, "u2_pre");
    bcd = 8'h98;
    ld  = 1'b1;
    expect_run(2'b01, 7'h5B, 1, "u2_ld");
    ld  = 1'b0;
    expect_run(2'b01, 7'h5B, 1, "u2_post");
    expect_run(2'b00, 7'h00, 1, "gap98");
    expect_run(2'b10, 7'h6F, 4, "t9");
    expect_run(2'b00, 7'h00, 1, "gap98b");
    expect_run(2'b01, 7'h7F, 4, "u8");

    load(8'hA3);
    wait_for(2'b01, 7'h4F, "wA3");
    expect_run(2'b01, 7'h4F, 4, "u3");
    expect_run(2'b00, 7'h00, 1, "gapA3");
    expect_run(2'b10, 7'h40, 4, "dash");
    expect_run(2'b00, 7'h00, 1, "gapA3b");

    expect_run(2'b01, 7'h4F, 4, "u3b");
    expect_run(2'b00, 7'h00, 1, "gapA3c");
    expect_run(2'b10, 7'h40, 2, "dash_pre_en");
    en = 1'b0;
    expect_run(2'b10, 7'h40, 1, "dash_en_edge");
    expect_run(2'b00, 7'h00, 2, "en_off");
    en = 1'b1;
    expect_run(2'b00, 7'h00, 2, "en_restart");
    expect_run(2'b01, 7'h4F, 4, "u3_restart");
    expect_run(2'b00, 7'h00, 1, "gap_restart");
    expect_run(2'b10, 7'h40, 4, "dash_restart");

    load(8'h42);
    wait_for(2'b01, 7'h5B, "w42");
    expect_run(2'b01, 7'h5B, 2, "u2_42");
    rst = 1'b1;
    expect_run(2'b01, 7'h5B, 1, "u2_rst_edge");
    rst = 1'b0;
    expect_run(2'b00, 7'h00, 2, "post_rst");
    expect_run(2'b01, 7'h3F, 4, "u0_rst");
    expect_run(2'b00, 7'h00, 6, "lz_rst");
    expect_run(2'b01, 7'h3F, 1, "u0_rst_again");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Consumes the 8-bit two-digit BCD word (tens in [7:4], units in [3:0]) produced by the binary-to-BCD decoder and time-multiplexes it onto a shared 7-segment bus with two digit enables.
- Sits directly downstream of the decoder, between it and the board display pins.
- Provides a load-strobed shadow register, dead-time between digits, leading-zero blanking and a dash for non-BCD nibbles.

Parameters:
- DIGIT_CYCLES, 1000, clock cycles each digit is driven; legal range is 1 or more.
- GAP_CYCLES, 16, blank dead-time cycles after each digit slot; 0 means no gap state is entered.
- BLANK_LZ, 1, 1 means a tens digit of 0 is shown blank.
- SEG_ACTIVE_LOW, 0, 1 means seg and an are inverted at the output register.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- bcd  input  8  BCD word from the decoder.
- ld  input  1  load strobe; bcd is captured into the shadow register when ld=1.
- en  input  1  display enable.
- seg  output  7  segments {g,f,e,d,c,b,a}, registered.
- an  output  2  digit enables; an[0] is units, an[1] is tens; registered.

Behaviour:
- Reset (rst=1 at an edge):
  - shadow=8'h00, state=S_LO, cnt=0.
  - seg=7'h00 and an=2'b00, before polarity inversion.
  - rst has priority over ld and en.
- Shadow register:
  - ld=1 at edge N means shadow=bcd from N+1.
  - ld with en=0 still loads.
- Slot capture:
  - The digit value is sampled from shadow on entry to each digit slot and held for the whole slot.
  - A mid-slot ld therefore never changes the digit being shown; it appears at the next slot of that digit.
- FSM states, in order: S_LO -> S_GAP_LO -> S_HI -> S_GAP_HI -> S_LO.
  - Digit states last DIGIT_CYCLES cycles; gap states last GAP_CYCLES cycles.
  - cnt counts 0..limit-1. The transition happens and cnt clears on the cycle cnt==limit-1.
  - If GAP_CYCLES==0, both gap states are skipped.
  - cnt width is $clog2 of max(DIGIT_CYCLES, GAP_CYCLES, 2).
- Outputs:
  - Registered, with one cycle of latency from the state to the pins.
  - S_LO: an=01, seg=enc(units).
  - S_HI: an=10, seg=enc(tens).
  - Gap states: an=00, seg=00.
- Encoding (active-high):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any nibble A..F gives a dash, 40.
- Leading-zero blanking:
  - Applies when BLANK_LZ=1 and the captured tens nibble is 0.
  - S_HI then outputs an=00, seg=00; slot timing is unchanged.
  - The units digit is never blanked, so 00 displays as "0".
- en=0:
  - Next edge: state=S_LO, cnt=0, outputs blank.
  - The FSM holds there while en=0.
  - On the first edge with en=1, the scan restarts from S_LO with a fresh capture.
- Simultaneous ld and slot entry on the same edge: the capture uses the old shadow; the new value appears at the following slot.
- Reset mid-scan returns to the reset values on the next edge, regardless of state.
- SEG_ACTIVE_LOW=1 inverts both seg and an, including their reset values (seg=7F, an=11).

Decomposition:
- Package bcd_disp_pkg:
  - state_t enum {S_LO, S_GAP_LO, S_HI, S_GAP_HI}.
  - SEG_BLANK=7'h00, SEG_DASH=7'h40.
  - The ten digit-pattern constants.
- Sub-module bcd_to_7seg: combinational 4-bit to 7-bit encoder including the dash rule. It is instantiated once on the muxed nibble.

Test Plan (DIGIT_CYCLES=4, GAP_CYCLES=1, BLANK_LZ=1, SEG_ACTIVE_LOW=0):
- Reset, then en=1, ld=1 for one cycle with bcd=8'h15 -> repeating period of 10 cycles: an=01/seg=6D for 4 cycles, 00/00 for 1, an=10/seg=06 for 4, 00/00 for 1.
- ld with bcd=8'h07 -> the tens slot has an=00, seg=00 (blanked); the units slot shows seg=07. Then bcd=8'h00 -> units shows 3F and tens stays blank.
- Load 8'h12, then pulse ld with 8'h98 at cycle 2 of an S_LO slot -> the rest of that slot stays 5B. The next S_HI shows 6F and the next S_LO shows 7F.
- Load 8'hA3 -> units shows 4F; the tens slot shows dash 40 and is not blanked.
- Drop en for 3 cycles mid-S_HI -> an=00/seg=00 from the next cycle. When en returns, S_LO is the first driven slot, lasting a full 4 cycles.
- Assert rst mid-S_LO with shadow=8'h42 -> the next cycle shows an=00, seg=00. With en=1 and no new ld, the display shows units 3F; tens 0 is blanked.
